// File: rtl/mem_stage_request_if.sv
// mem_stage_request_if: pipeline and data-cache signals of the memory stage
interface mem_stage_request_if #(parameter int ADDR_W = 32, DATA_W = 32, CNT_W = 16);
  logic MemRead_mem, MemWrite_mem, halt_mem, advance, dhit, dflushed;
  logic [ADDR_W-1:0] dmemaddr_mem, daddr;
  logic [DATA_W-1:0] dmemstore_mem, dload, dstore, dmemload_mem;
  logic dREN, dWEN, dcache_halt, mem_stall, halted, op_conflict;
  logic [CNT_W-1:0] access_cnt, stall_cnt;
  modport master (
    output MemRead_mem, MemWrite_mem, halt_mem, dmemaddr_mem, dmemstore_mem, advance, dhit, dload, dflushed,
    input dREN, dWEN, daddr, dstore, dcache_halt, dmemload_mem, mem_stall, halted, op_conflict, access_cnt, stall_cnt
  );
  modport slave (
    input MemRead_mem, MemWrite_mem, halt_mem, dmemaddr_mem, dmemstore_mem, advance, dhit, dload, dflushed,
    output dREN, dWEN, daddr, dstore, dcache_halt, dmemload_mem, mem_stall, halted, op_conflict, access_cnt, stall_cnt
  );
endinterface

// File: rtl/mem_stage_request.sv
// mem_stage_request: issues one cache access per memory op, stalls until hit, sequences halt flush
module mem_stage_request #(parameter int ADDR_W = 32, DATA_W = 32, CNT_W = 16) (
  input logic CLK,
  input logic RST,
  mem_stage_request_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ACCESS, DONE, FLUSH, HALTED} state_t;
  state_t state, state_n;
  logic rd, wr, op_conflict, req, stall;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore, dmemload;
  logic [CNT_W-1:0] access_cnt, stall_cnt;
  assign req = bus.MemRead_mem | bus.MemWrite_mem;
  // Pending access wins over halt: the halt is only taken from IDLE with no request.
  always_comb begin
    state_n = state == IDLE   ? (req ? ACCESS : bus.halt_mem ? FLUSH : IDLE) :
              state == ACCESS ? (bus.dhit ? DONE : ACCESS) :
              state == DONE   ? (bus.advance ? IDLE : DONE) :
              state == FLUSH  ? (bus.dflushed ? HALTED : FLUSH) : HALTED;
    stall = !RST && ((state == IDLE && req) || state == ACCESS || state == FLUSH || state == HALTED);
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      rd <= 1'b0;
      wr <= 1'b0;
      op_conflict <= 1'b0;
      daddr <= '0;
      dstore <= '0;
      dmemload <= '0;
      access_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && req) begin
        daddr <= bus.dmemaddr_mem;
        dstore <= bus.dmemstore_mem;
        wr <= bus.MemWrite_mem;
        rd <= bus.MemRead_mem & ~bus.MemWrite_mem;
        op_conflict <= op_conflict | (bus.MemRead_mem & bus.MemWrite_mem);
      end
      if (state == ACCESS && bus.dhit) begin
        if (rd) dmemload <= bus.dload;
        if (!(&access_cnt)) access_cnt <= access_cnt + CNT_W'(1);
      end
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
  assign bus.dREN = state == ACCESS && rd;
  assign bus.dWEN = state == ACCESS && wr;
  assign bus.daddr = daddr;
  assign bus.dstore = dstore;
  assign bus.dcache_halt = state == FLUSH;
  assign bus.halted = state == HALTED;
  assign bus.dmemload_mem = dmemload;
  assign bus.mem_stall = stall;
  assign bus.op_conflict = op_conflict;
  assign bus.access_cnt = access_cnt;
  assign bus.stall_cnt = stall_cnt;
endmodule

// File: tb/tb_mem_stage_request.sv
// tb_mem_stage_request: directed and random checks against a transaction-level model
module tb_mem_stage_request;
  localparam int CNT_W = 4;
  localparam int CMAX = 2 ** CNT_W - 1;
  logic CLK = 1'b0, RST = 1'b1;
  int checks = 0, failures = 0, ren_n = 0, wen_n = 0;
  bit m_busy, m_done, m_flush, m_halted, m_rd, m_wr, m_conf;
  logic [31:0] m_addr, m_store, m_load;
  int m_acc, m_stall;
  mem_stage_request_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(CNT_W)) bus ();
  mem_stage_request #(.ADDR_W(32), .DATA_W(32), .CNT_W(CNT_W)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    {m_busy, m_done, m_flush, m_halted, m_rd, m_wr, m_conf} = '0;
    m_addr = 0; m_store = 0; m_load = 0; m_acc = 0; m_stall = 0;
  endtask
  // One cycle: drive at negedge, check before the edge, advance the model at the edge.
  task automatic cyc(input bit r, rd, wr, h, adv, hit, fl, input logic [31:0] a, s, l);
    bit idle, req, stall;
    RST = r;
    bus.MemRead_mem = rd; bus.MemWrite_mem = wr; bus.halt_mem = h; bus.advance = adv;
    bus.dhit = hit; bus.dflushed = fl; bus.dmemaddr_mem = a; bus.dmemstore_mem = s; bus.dload = l;
    if (r) model_reset();
    #1;
    req = rd | wr;
    idle = !(m_busy || m_done || m_flush || m_halted);
    stall = !r && ((idle && req) || m_busy || m_flush || m_halted);
    chk("dREN", bus.dREN, m_busy && m_rd);
    chk("dWEN", bus.dWEN, m_busy && m_wr);
    chk("daddr", bus.daddr, m_addr);
    chk("dstore", bus.dstore, m_store);
    chk("dcache_halt", bus.dcache_halt, m_flush);
    chk("halted", bus.halted, m_halted);
    chk("dmemload", bus.dmemload_mem, m_load);
    chk("mem_stall", bus.mem_stall, stall);
    chk("op_conflict", bus.op_conflict, m_conf);
    chk("access_cnt", bus.access_cnt, m_acc);
    chk("stall_cnt", bus.stall_cnt, m_stall);
    if (bus.dREN === 1'b1) ren_n++;
    if (bus.dWEN === 1'b1) wen_n++;
    @(posedge CLK);
    if (!r) begin
      if (stall && m_stall < CMAX) m_stall++;
      if (idle) begin
        if (req) begin
          m_busy = 1; m_wr = wr; m_rd = rd && !wr; m_addr = a; m_store = s; m_conf |= rd && wr;
        end else if (h) m_flush = 1;
      end else if (m_busy) begin
        if (hit) begin
          m_busy = 0; m_done = 1;
          if (m_acc < CMAX) m_acc++;
          if (m_rd) m_load = l;
        end
      end else if (m_done) begin
        if (adv) m_done = 0;
      end else if (m_flush && fl) begin
        m_flush = 0; m_halted = 1;
      end
    end
    @(negedge CLK);
  endtask
  task automatic rnd(input bit r);
    cyc(r, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
        $urandom, $urandom, $urandom);
  endtask
  initial begin
    model_reset();
    @(negedge CLK);
    // reset with random inputs
    rnd(1); rnd(1);
    chk("rst_stall", bus.mem_stall, 0);
    // load at 0x40, hit in third access cycle
    ren_n = 0;
    cyc(0, 1, 0, 0, 0, 0, 0, 32'h40, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 32'h40, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 32'h40, 0, 0);
    cyc(0, 1, 0, 0, 0, 1, 0, 32'h40, 0, 32'hDEADBEEF);
    chk("load_ren_cycles", ren_n, 3);
    chk("load_daddr", bus.daddr, 32'h40);
    chk("load_data", bus.dmemload_mem, 32'hDEADBEEF);
    chk("load_access_cnt", bus.access_cnt, 1);
    chk("load_stall_cnt", bus.stall_cnt, 4);
    chk("load_done_stall", bus.mem_stall, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    // store, hit at once, hold in DONE
    wen_n = 0;
    cyc(0, 0, 1, 0, 0, 0, 0, 32'h80, 32'h12345678, 0);
    cyc(0, 0, 1, 0, 0, 1, 0, 32'h80, 32'h12345678, 32'h55555555);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 1, 0, 32'h80, 32'h12345678, 0);
    chk("store_wen_cycles", wen_n, 1);
    chk("store_dstore", bus.dstore, 32'h12345678);
    chk("store_keeps_load", bus.dmemload_mem, 32'hDEADBEEF);
    cyc(0, 0, 1, 0, 1, 0, 0, 32'h80, 32'h12345678, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("store_back_idle", bus.mem_stall, 0);
    // read+write conflict
    ren_n = 0; wen_n = 0;
    cyc(0, 1, 1, 0, 0, 0, 0, 32'hC0, 32'hA5A5A5A5, 0);
    cyc(0, 1, 1, 0, 0, 1, 0, 32'hC0, 32'hA5A5A5A5, 32'h0BADF00D);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("conf_wen", wen_n, 1);
    chk("conf_ren", ren_n, 0);
    chk("conf_flag", bus.op_conflict, 1);
    // halt with pending load
    cyc(0, 1, 0, 1, 0, 0, 0, 32'h100, 0, 0);
    cyc(0, 1, 0, 1, 0, 1, 0, 32'h100, 0, 32'hCAFEF00D);
    cyc(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("halt_flush_req", bus.dcache_halt, 1);
    chk("halt_load_done", bus.dmemload_mem, 32'hCAFEF00D);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) rnd(0);
    chk("halt_sticky", bus.halted, 1);
    chk("halt_flush_off", bus.dcache_halt, 0);
    // reset mid-access drops dREN at once
    rnd(1);
    cyc(0, 1, 0, 0, 0, 0, 0, 32'h200, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 32'h200, 0, 0);
    chk("mid_ren_before", bus.dREN, 1);
    RST = 1'b1;
    #1;
    chk("mid_ren_async", bus.dREN, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 32'h200, 0, 0);
    // stall counter saturation
    for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0, 0, 0, 0, 32'h300, 0, 0);
    chk("stall_saturated", bus.stall_cnt, CMAX);
    // random traffic with occasional reset
    for (int i = 0; i < 600; i++) rnd($urandom_range(0, 39) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_stage_request.md
# mem_stage_request

Memory-stage data-access controller. It sits between the EX/MEM latch outputs and the data cache, and is the producer side of the MEM/WB interface. It issues one read or write request per memory instruction and holds the request stable until the cache returns a hit. It captures load data onto `dmemload_mem` and stalls the pipeline while the access is outstanding. On `halt` it sequences a data-cache flush before reporting the processor halted. It also keeps saturating performance counters.

## Interface
- `ADDR_W`, 32, data address width
- `DATA_W`, 32, data word width
- `CNT_W`, 16, performance counter width

- `CLK` in 1: sole clock, rising edge
- `RST` in 1: asynchronous, active-high reset
- `MemRead_mem` in 1: current MEM instruction is a load
- `MemWrite_mem` in 1: current MEM instruction is a store
- `halt_mem` in 1: current MEM instruction is halt
- `dmemaddr_mem` in ADDR_W: access address
- `dmemstore_mem` in DATA_W: store data
- `advance` in 1: pipeline latches the MEM/WB register this cycle (same signal as the MEM/WB enable)
- `dhit` in 1: cache completes the current access
- `dload` in DATA_W: cache read data, valid when `dhit`=1
- `dflushed` in 1: cache flush complete
- `dREN` out 1: cache read request
- `dWEN` out 1: cache write request
- `daddr` out ADDR_W: registered request address
- `dstore` out DATA_W: registered store data
- `dcache_halt` out 1: request cache flush
- `dmemload_mem` out DATA_W: captured load data, to MEM/WB
- `mem_stall` out 1: hold all pipeline latches upstream of and including MEM/WB
- `halted` out 1: processor halted, sticky
- `op_conflict` out 1: sticky, set when read and write are both requested
- `access_cnt` out CNT_W: completed accesses, saturating
- `stall_cnt` out CNT_W: cycles with `mem_stall`=1, saturating

## Operation
- States: IDLE, ACCESS, DONE, FLUSH, HALTED.
- **IDLE**
  - A memory op is `req = MemRead_mem | MemWrite_mem`. If `req`=1: latch address, store data and op type into `daddr`/`dstore`/op, then go to ACCESS.
  - Else if `halt_mem`=1: go to FLUSH.
- **ACCESS**
  - `dREN` = latched read, `dWEN` = latched write. `daddr`/`dstore` stay stable.
  - On `dhit`=1: capture `dload` into `dmemload_mem` (reads only; writes leave it unchanged), increment `access_cnt`, go to DONE.
- **DONE**
  - No request is driven.
  - If `advance`=1, go to IDLE. Otherwise hold, so the same instruction is never re-issued.
- **FLUSH**
  - `dcache_halt`=1.
  - On `dflushed`=1, go to HALTED.
- **HALTED**
  - `halted`=1, `dcache_halt`=0. No requests. Only `RST` exits this state.
- **Read and write both set:** perform the write only, and set `op_conflict` (sticky until reset).
- **`halt_mem` together with `req`:** the access completes first (IDLE → ACCESS → DONE → IDLE), then the halt is taken from IDLE.
- **`mem_stall`** = (IDLE & `req`) | ACCESS | FLUSH | HALTED. It is combinational from state and inputs.
- **Counters:** both saturate at all-ones and never wrap. `stall_cnt` increments on every cycle with `mem_stall`=1.

## Timing
- Reset: everything returns to IDLE, and every output is 0. `RST` asserted mid-access drops `dREN`/`dWEN` immediately (asynchronous) and discards the access.
- Cycle 0: IDLE with `req`=1, so `mem_stall`=1. Requests are not yet driven.
- Cycle 1 onward: ACCESS drives `dREN`/`dWEN`.
- `dhit` in cycle k ⇒ in cycle k+1 the state is DONE, `dmemload_mem` is valid and `mem_stall`=0.
- Minimum access latency is 2 cycles of stall (`dhit` at cycle 1). The stall count equals k+1.
- `dmemload_mem` holds its value until the next completed read or reset.
- `dhit` outside ACCESS is ignored. `dflushed` outside FLUSH is ignored.

## Test plan
- **Reset:** assert `RST` for 2 cycles with random inputs → all outputs 0, state IDLE.
- **Load, hit after 3 cycles:** load at address 0x0000_0040, `dload`=0xDEAD_BEEF, `dhit` in the 3rd ACCESS cycle → `dREN`=1 for 3 cycles, `daddr`=0x40, `dmemload_mem`=0xDEAD_BEEF. `mem_stall`=1 for 4 cycles, `access_cnt`=1, `stall_cnt`=4.
- **Store, then hold in DONE:** store with `dmemstore_mem`=0x1234_5678, `dhit` in the 1st ACCESS cycle, `advance`=0 for 3 cycles → `dWEN`=1 for 1 cycle, `dstore`=0x1234_5678. No second request while in DONE. Return to IDLE on `advance`.
- **Read+write conflict:** `MemRead_mem`=`MemWrite_mem`=1 → only `dWEN` is asserted, `op_conflict`=1 and stays 1.
- **Halt with pending load:** load and `halt_mem` set together → the load completes, then `dcache_halt`=1. `dflushed` after 5 cycles → `halted`=1 and stays 1 while inputs toggle.
- **Reset mid-access, then saturation:** assert `RST` during ACCESS → `dREN` falls asynchronously. With `CNT_W`=4, run 20 stall cycles → `stall_cnt`=15.
